// File: rtl/uart_pkt_rx.sv
// Polls a UART register port one byte at a time, assembles SYNC/LEN/payload/CSUM frames,
// answers each with ACK or NAK, and streams accepted payloads out over a valid/ready port.
module uart_pkt_rx #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic        uart_stb_o,
  output logic        uart_we_o,
  output logic [31:0] uart_adr_o,
  output logic [31:0] uart_dat_o,
  input  logic [31:0] uart_dat_i,
  input  logic        uart_ack_i,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        pkt_last,
  output logic [4:0]  pkt_len,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH     = 1 << IW;
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [31:0] ACK_CODE  = 32'h0000_0006;
  localparam logic [31:0] NAK_CODE  = 32'h0000_0015;

  typedef enum logic [2:0] {
    S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_REPLY, S_DRAIN
  } state_t;

  typedef enum logic {
    PH_REQ, PH_SAMPLE
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [7:0]    sum_q, sum_d;
  logic [4:0]    idx_q, idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [TW-1:0] to_q, to_d;
  logic [4:0]    len_d;
  logic          ack_q, ack_d;
  logic          err_inc;
  logic          buf_we;
  logic          fetching;
  logic          got_byte;
  logic [7:0]    rx_byte;
  logic          stb_d;
  logic          fetch_d;
  logic [7:0]    buf_q [DEPTH];

  // The UART answers in the same cycle, so its ack and the upper read-data bits carry no information.
  logic unused_ok;
  assign unused_ok = ^{uart_ack_i, uart_dat_i[31:9]};

  // The register port is always addressed at offset zero.
  assign uart_adr_o = 32'h0;

  assign fetching = (state_q == S_HUNT) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign got_byte = fetching && (phase_q == PH_SAMPLE) && uart_dat_i[8];
  assign rx_byte  = uart_dat_i[7:0];

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    to_d     = to_q;
    len_d    = pkt_len;
    ack_d    = ack_q;
    err_inc  = 1'b0;
    buf_we   = 1'b0;

    // A REQ cycle only counts once the strobe is actually on the bus.
    if (fetching) begin
      if (phase_q == PH_REQ) begin
        if (uart_stb_o) phase_d = PH_SAMPLE;
      end else begin
        phase_d = PH_REQ;
      end
    end

    unique case (state_q)
      S_HUNT: begin
        if (got_byte && (rx_byte == SYNC)) state_d = S_LEN;
      end
      S_LEN: begin
        if (got_byte) begin
          if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN_B)) begin
            state_d = S_REPLY;
            ack_d   = 1'b0;
            err_inc = 1'b1;
          end else begin
            len_d   = rx_byte[4:0];
            sum_d   = rx_byte;
            idx_d   = 5'd0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (got_byte) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_byte;
          idx_d  = idx_q + 5'd1;
          if ((idx_q + 5'd1) == pkt_len) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (got_byte) begin
          state_d = S_REPLY;
          if ((sum_q + rx_byte) == 8'h00) begin
            ack_d = 1'b1;
          end else begin
            ack_d   = 1'b0;
            err_inc = 1'b1;
          end
        end
      end
      S_REPLY: begin
        state_d  = ack_q ? S_DRAIN : S_HUNT;
        rd_idx_d = '0;
      end
      S_DRAIN: begin
        if (pkt_valid && pkt_ready) begin
          if (pkt_last) state_d = S_HUNT;
          else          rd_idx_d = rd_idx_q + IW'(1);
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Inter-byte timeout only runs while a frame is partially received.
    if ((state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM)) begin
      if (got_byte) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        to_d    = '0;
        state_d = S_HUNT;
        err_inc = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = '0;
    end

    if (state_d != state_q) phase_d = PH_REQ;

    fetch_d = (state_d == S_HUNT) || (state_d == S_LEN) ||
              (state_d == S_PAYLOAD) || (state_d == S_CSUM);
    // Never strobe twice in a row: a fetch REQ following a strobed cycle waits one cycle.
    stb_d = (state_d == S_REPLY) || (fetch_d && (phase_d == PH_REQ) && !uart_stb_o);
  end

  // State, datapath and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_HUNT;
      phase_q    <= PH_REQ;
      sum_q      <= 8'h00;
      idx_q      <= 5'd0;
      rd_idx_q   <= '0;
      to_q       <= '0;
      ack_q      <= 1'b0;
      uart_stb_o <= 1'b0;
      uart_we_o  <= 1'b0;
      uart_dat_o <= 32'h0;
      pkt_data   <= 8'h00;
      pkt_valid  <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_len    <= 5'd0;
      err_cnt    <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      to_q       <= to_d;
      ack_q      <= ack_d;
      uart_stb_o <= stb_d;
      uart_we_o  <= (state_d == S_REPLY);
      uart_dat_o <= (state_d == S_REPLY) ? (ack_d ? ACK_CODE : NAK_CODE) : 32'h0;
      pkt_valid  <= (state_d == S_DRAIN);
      pkt_data   <= (state_d == S_DRAIN) ? buf_q[rd_idx_d] : 8'h00;
      pkt_last   <= (state_d == S_DRAIN) && (5'(rd_idx_d) == (len_d - 5'd1));
      pkt_len    <= len_d;
      busy       <= (state_d != S_HUNT);
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'h01;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge sys_clk) begin
    if (buf_we) buf_q[IW'(idx_q)] <= rx_byte;
  end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Self-checking bench for uart_pkt_rx: a UART byte-source model feeds frames, a monitor
// scores reply writes and the payload stream against queued expectations.
module tb_uart_pkt_rx;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        uart_stb_o;
  logic        uart_we_o;
  logic [31:0] uart_adr_o;
  logic [31:0] uart_dat_o;
  logic [31:0] uart_dat_i;
  logic        uart_ack_i;
  logic [7:0]  pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_last;
  logic [4:0]  pkt_len;
  logic [7:0]  err_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int err_exp = 0;

  logic [7:0]  rx_q[$];
  logic [31:0] exp_reply[$];
  logic [8:0]  exp_stream[$];

  logic toggle_en = 1'b0;

  uart_pkt_rx #(.SYNC(8'hA5), .MAX_LEN(16), .TIMEOUT(100)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .uart_stb_o(uart_stb_o), .uart_we_o(uart_we_o), .uart_adr_o(uart_adr_o),
    .uart_dat_o(uart_dat_o), .uart_dat_i(uart_dat_i), .uart_ack_i(uart_ack_i),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_last(pkt_last), .pkt_len(pkt_len), .err_cnt(err_cnt), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  assign uart_ack_i = uart_stb_o;

  // UART model: data for a read appears in the cycle after the strobe.
  logic req_pend = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      uart_dat_i = 32'h0;
      req_pend   = 1'b0;
    end else begin
      if (req_pend && rx_q.size() > 0) uart_dat_i = {23'h0, 1'b1, rx_q.pop_front()};
      else                             uart_dat_i = 32'h0;
      req_pend = uart_stb_o && !uart_we_o;
    end
  end

  // Sink ready: always high, or toggling every 3 cycles.
  int tcnt = 0;
  always @(posedge sys_clk) begin
    #1;
    if (!toggle_en) begin
      pkt_ready = 1'b1;
      tcnt = 0;
    end else begin
      tcnt++;
      if (tcnt == 3) begin
        pkt_ready = ~pkt_ready;
        tcnt = 0;
      end
    end
  end

  // Monitor: protocol rules, reply scoreboard, stream scoreboard, stall stability.
  logic       prev_stb = 1'b0;
  logic       stall_prev = 1'b0;
  logic [8:0] held = 9'h0;
  always @(negedge sys_clk) begin
    logic [31:0] er;
    logic [8:0]  es;
    if (sys_rst_n) begin
      n_cmp++;
      if (prev_stb && uart_stb_o) begin
        n_bad++; $display("FAIL stb_consecutive: stb high two cycles at %0t", $time);
      end
      n_cmp++;
      if (uart_adr_o !== 32'h0) begin
        n_bad++; $display("FAIL adr_zero: got %h expected 0", uart_adr_o);
      end
      if (uart_stb_o && uart_we_o) begin
        n_cmp++;
        if (exp_reply.size() == 0) begin
          n_bad++; $display("FAIL unexpected_reply: got %h expected none", uart_dat_o);
        end else begin
          er = exp_reply.pop_front();
          if (uart_dat_o !== er) begin
            n_bad++; $display("FAIL reply: got %h expected %h", uart_dat_o, er);
          end
        end
      end
      if (stall_prev) begin
        n_cmp++;
        if (pkt_valid !== 1'b1 || {pkt_last, pkt_data} !== held) begin
          n_bad++; $display("FAIL stall_hold: got v=%b %h expected v=1 %h", pkt_valid, {pkt_last, pkt_data}, held);
        end
      end
      if (pkt_valid && pkt_ready) begin
        n_cmp++;
        if (exp_stream.size() == 0) begin
          n_bad++; $display("FAIL unexpected_stream: got %h expected none", {pkt_last, pkt_data});
        end else begin
          es = exp_stream.pop_front();
          if ({pkt_last, pkt_data} !== es) begin
            n_bad++; $display("FAIL stream: got last=%b data=%h expected last=%b data=%h", pkt_last, pkt_data, es[8], es[7:0]);
          end
        end
      end
      stall_prev = pkt_valid && !pkt_ready;
      held       = {pkt_last, pkt_data};
      prev_stb   = uart_stb_o;
    end else begin
      prev_stb   = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) rx_q.push_back(b[i]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while ((rx_q.size() != 0 || exp_reply.size() != 0 || exp_stream.size() != 0 || busy) && cyc < budget) begin
      @(negedge sys_clk);
      cyc++;
    end
    n_cmp++;
    if (cyc >= budget) begin
      n_bad++;
      $display("FAIL %s_done: still busy after %0d cycles (rx=%0d rep=%0d str=%0d) expected idle", name, cyc, rx_q.size(), exp_reply.size(), exp_stream.size());
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({uart_stb_o, uart_we_o, pkt_valid, pkt_last, busy} !== 5'b0 || uart_dat_o !== 32'h0 ||
        uart_adr_o !== 32'h0 || {pkt_data, pkt_len, err_cnt} !== 21'h0) begin
      n_bad++;
      $display("FAIL reset_values: got stb=%b we=%b v=%b last=%b busy=%b dat=%h adr=%h pd=%h len=%h err=%h expected all 0",
               uart_stb_o, uart_we_o, pkt_valid, pkt_last, busy, uart_dat_o, uart_adr_o, pkt_data, pkt_len, err_cnt);
    end
    sys_rst_n = 1'b1;
    check_poll_start("reset_release");
  endtask

  task automatic check_poll_start(input string name);
    int c = 0;
    while (!uart_stb_o && c < 3) begin
      @(negedge sys_clk);
      c++;
    end
    n_cmp++;
    if (uart_stb_o !== 1'b1) begin
      n_bad++; $display("FAIL %s_first_stb: got no stb within %0d cycles expected within 2", name, c);
    end
  endtask

  task automatic check_status(input string name, input int len);
    n_cmp++;
    if (err_cnt !== 8'(err_exp)) begin
      n_bad++; $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, err_exp);
    end
    if (len >= 0) begin
      n_cmp++;
      if (pkt_len !== 5'(len)) begin
        n_bad++; $display("FAIL %s_pkt_len: got %0d expected %0d", name, pkt_len, len);
      end
    end
  endtask

  task automatic test_good_frame();
    push_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
    exp_reply.push_back(32'h06);
    exp_stream.push_back({1'b0, 8'h11});
    exp_stream.push_back({1'b0, 8'h22});
    exp_stream.push_back({1'b1, 8'h33});
    wait_done("good", 500);
    check_status("good", 3);
  endtask

  task automatic test_bad_csum();
    push_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98});
    exp_reply.push_back(32'h15);
    err_exp++;
    wait_done("bad_csum", 500);
    check_status("bad_csum", 3);
    n_cmp++;
    if (busy !== 1'b0 || pkt_valid !== 1'b0) begin
      n_bad++; $display("FAIL bad_csum_hunt: got busy=%b valid=%b expected 0 0", busy, pkt_valid);
    end
  endtask

  task automatic test_bad_len();
    push_bytes('{8'hA5, 8'h00, 8'hA5, 8'h11});
    exp_reply.push_back(32'h15);
    exp_reply.push_back(32'h15);
    err_exp += 2;
    wait_done("bad_len", 500);
    check_status("bad_len", -1);
  endtask

  task automatic test_sync_as_data();
    push_bytes('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'h5A});
    exp_reply.push_back(32'h06);
    exp_stream.push_back({1'b1, 8'hA5});
    wait_done("sync_data", 500);
    check_status("sync_data", 1);
  endtask

  task automatic test_back_to_back();
    push_bytes('{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE, 8'hA5, 8'h01, 8'h7F, 8'h80});
    exp_reply.push_back(32'h06);
    exp_stream.push_back({1'b0, 8'h10});
    exp_stream.push_back({1'b1, 8'h20});
    exp_reply.push_back(32'h06);
    exp_stream.push_back({1'b1, 8'h7F});
    wait_done("b2b", 800);
    check_status("b2b", 1);
  endtask

  task automatic test_timeout();
    int c = 0;
    int idle = 0;
    push_bytes('{8'hA5, 8'h02, 8'h7E});
    while (rx_q.size() != 0 && c < 200) begin
      @(negedge sys_clk);
      c++;
    end
    while (busy !== 1'b0 && idle < 400) begin
      @(negedge sys_clk);
      idle++;
    end
    err_exp++;
    n_cmp++;
    if (idle < 95 || idle > 110) begin
      n_bad++; $display("FAIL timeout_cycles: got %0d idle cycles expected about 100", idle);
    end
    repeat (4) @(negedge sys_clk);
    check_status("timeout", -1);
  endtask

  task automatic test_stall_reset();
    int c = 0;
    toggle_en = 1'b1;
    push_bytes('{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2});
    exp_reply.push_back(32'h06);
    exp_stream.push_back({1'b0, 8'h01});
    exp_stream.push_back({1'b0, 8'h02});
    exp_stream.push_back({1'b0, 8'h03});
    exp_stream.push_back({1'b1, 8'h04});
    while (exp_stream.size() > 2 && c < 500) begin
      @(negedge sys_clk);
      c++;
    end
    n_cmp++;
    if (c >= 500) begin
      n_bad++; $display("FAIL stall_progress: got %0d bytes left expected 2", exp_stream.size());
    end
    n_cmp++;
    if (pkt_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_mid_drain: got valid=%b expected 1", pkt_valid);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    exp_stream.delete();
    rx_q.delete();
    toggle_en = 1'b0;
    err_exp = 0;
    n_cmp++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'h00 || uart_stb_o !== 1'b0) begin
      n_bad++; $display("FAIL stall_reset_async: got v=%b busy=%b err=%0d stb=%b expected 0", pkt_valid, busy, err_cnt, uart_stb_o);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check_poll_start("stall_reset");
    repeat (10) @(negedge sys_clk);
    n_cmp++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL stall_after_reset: got v=%b busy=%b expected 0 0", pkt_valid, busy);
    end
    check_status("stall_reset", -1);
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) begin
      rx_q.push_back(8'hA5);
      rx_q.push_back(8'h00);
      exp_reply.push_back(32'h15);
    end
    err_exp = 255;
    wait_done("saturate", 8000);
    check_status("saturate", -1);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_sync_as_data();
    test_back_to_back();
    test_timeout();
    test_stall_reset();
    test_err_saturate();
    n_cmp++;
    if (exp_reply.size() != 0 || exp_stream.size() != 0) begin
      n_bad++; $display("FAIL leftover: got rep=%0d str=%0d expected 0 0", exp_reply.size(), exp_stream.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_pkt_rx.md
UART_PKT_RX -- requirements
Module: uart_pkt_rx

Interface
REQ-001 SHALL have parameter SYNC, default 8'hA5, frame start byte.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (range 1..16).
REQ-003 SHALL have parameter TIMEOUT, default 1000000, inter-byte timeout in sys_clk cycles.
REQ-004 SHALL have ports: sys_clk in 1, sole clock; sys_rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: uart_stb_o out 1, uart_we_o out 1, uart_adr_o out 32, uart_dat_o out 32 (bus master toward the UART register port).
REQ-006 SHALL have ports: uart_dat_i in 32, UART read data; uart_ack_i in 1, UART acknowledge.
REQ-007 SHALL have ports: pkt_data out 8, pkt_valid out 1, pkt_ready in 1, pkt_last out 1, pkt_len out 5 (payload stream).
REQ-008 SHALL have ports: err_cnt out 8, saturating frame-error count; busy out 1, high when not in HUNT.

Function
REQ-009 Byte fetch SHALL take two cycles: REQ (stb_o=1, we_o=0, adr_o=0) then SAMPLE (stb_o=0); uart_dat_i[8]=1 in SAMPLE means byte uart_dat_i[7:0] received, 0 means none.
REQ-010 stb_o SHALL never be high in two consecutive cycles; uart_adr_o SHALL always be 0.
REQ-011 Frame format SHALL be: SYNC, LEN, LEN payload bytes, CSUM; valid when (LEN + payload + CSUM) mod 256 == 0.
REQ-012 Frame FSM states SHALL be HUNT, LEN, PAYLOAD, CSUM, REPLY, DRAIN.
REQ-013 HUNT: fetch bytes; non-SYNC bytes discarded without error; SYNC -> LEN.
REQ-014 LEN: byte 0 or > MAX_LEN -> REPLY with NAK, err_cnt+1; else latch pkt_len, init sum=LEN, index=0 -> PAYLOAD.
REQ-015 PAYLOAD: each byte written to buffer[index], sum += byte (8-bit wrap), index+1; after LEN bytes -> CSUM.
REQ-016 CSUM: (sum + byte) mod 256 == 0 -> REPLY with ACK; else REPLY with NAK, err_cnt+1.
REQ-017 REPLY: one cycle stb_o=1, we_o=1, uart_dat_o = 32'h06 (ACK) or 32'h15 (NAK); ACK -> DRAIN, NAK -> HUNT.
REQ-018 A SYNC byte inside LEN/PAYLOAD/CSUM SHALL be treated as data, not as a restart.
REQ-019 Timeout counter SHALL clear on every received byte and in HUNT; reaching TIMEOUT in LEN/PAYLOAD/CSUM -> HUNT, err_cnt+1, no reply.
REQ-020 DRAIN: no UART accesses; pkt_valid=1, pkt_data=buffer[rd_idx], pkt_last=1 on rd_idx==pkt_len-1; rd_idx advances on pkt_valid&pkt_ready.
REQ-021 pkt_data/pkt_last SHALL hold stable while pkt_valid=1 and pkt_ready=0.
REQ-022 Handshake on final byte SHALL return to HUNT next cycle with pkt_valid=0.
REQ-023 pkt_valid SHALL be 0 outside DRAIN; failed frames SHALL never emit payload.
REQ-024 err_cnt SHALL saturate at 255.
REQ-025 uart_ack_i SHALL be ignored (UART acknowledges same cycle); data sampled in SAMPLE regardless.

Reset
REQ-026 While sys_rst_n=0, asynchronously: FSM=HUNT/REQ, stb_o=0, we_o=0, uart_dat_o=0, uart_adr_o=0, pkt_valid=0, pkt_last=0, pkt_data=0, pkt_len=0, err_cnt=0, busy=0, counters 0.
REQ-027 Reset mid-frame or mid-DRAIN SHALL discard the frame; first stb_o occurs within 2 cycles of release.
REQ-028 Buffer contents need not be reset.

Verification
REQ-029 Bytes A5 03 11 22 33 97, pkt_ready=1 -> write 0x06, stream 11,22,33 with pkt_last on 33, pkt_len=3, err_cnt=0.
REQ-030 Bytes A5 03 11 22 33 98 -> write 0x15, no pkt_valid, err_cnt=1, back in HUNT.
REQ-031 Bytes A5 00, then A5 11 (MAX_LEN=16) -> two NAKs, err_cnt=2, no payload.
REQ-032 Bytes 00 FF A5 01 A5 5A -> leading bytes ignored, ACK, single byte A5 with pkt_last, err_cnt=0.
REQ-033 TIMEOUT=100, bytes A5 02 7E then silence -> HUNT after 100 idle cycles, err_cnt=1, no write.
REQ-034 Good 4-byte frame with pkt_ready toggling every 3 cycles, sys_rst_n pulsed after byte 2 -> data stable under stall; after reset pkt_valid=0, err_cnt=0, polling resumes.
